// File: rtl/scan_sequencer.sv
// scan_sequencer
//   Sequences two line scanners that share one capture path. Scanner A is
//   started first. Scanner B is started once A reports 80% progress, so the
//   two scans overlap. Each scanner's serial transfer is then commanded in
//   turn. The bits are deserialized LSB-first and written as bytes into a
//   32x8 capture buffer.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle round request (ignored while busy)
//   cmd_a / cmd_b     scanner commands: 00 none, 01 start scan, 10 transfer
//   rdy_a / rdy_b     scanner 80%-progress flags
//   vld_a/dat_a,
//   vld_b/dat_b       serial bit streams (one bit per cycle while vld is high)
//   wr_en/wr_addr/
//   wr_data           capture buffer write port, addr = {scanner, byte index}
//   busy              high whenever the sequencer is not idle
//   done              one-cycle pulse at the end of a complete round
//   err               sticky timeout flag, cleared by rst or an accepted start
//
// States:
//   state   | meaning
//   IDLE    | waiting for start
//   START_A | cmd_a=01 for one cycle
//   WAIT_A  | waiting for rdy_a, timed
//   START_B | cmd_b=01 for one cycle
//   XFER_A  | receiving scanner A bytes, bit-gap timed
//   WAIT_B  | waiting for rdy_b (possibly already seen), timed
//   XFER_B  | receiving scanner B bytes, bit-gap timed
//   FINISH  | raise done, return to IDLE
//   ERR     | timeout: commands off, err set, return to IDLE
module scan_sequencer #(
  parameter int BYTES_PER_SCAN = 10,
  parameter int TIMEOUT        = 255,
  parameter int TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] cmd_a,
  input  logic       rdy_a,
  input  logic       vld_a,
  input  logic       dat_a,
  output logic [1:0] cmd_b,
  input  logic       rdy_b,
  input  logic       vld_b,
  input  logic       dat_b,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0]      CMD_NONE = 2'b00;
  localparam logic [1:0]      CMD_SCAN = 2'b01;
  localparam logic [1:0]      CMD_XFER = 2'b10;
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [3:0]      LAST_BYTE = 4'(BYTES_PER_SCAN - 1);

  typedef enum logic [3:0] {
    IDLE, START_A, WAIT_A, START_B, XFER_A, WAIT_B, XFER_B, FINISH, ERR
  } stateT;

  stateT           state;
  logic [TO_W-1:0] toCnt;
  logic [2:0]      bitCnt;
  logic [3:0]      byteCnt;
  logic [7:0]      shiftReg;
  logic            rdyBSeen;

  logic            xferB;
  logic            curVld;
  logic            curDat;
  logic [7:0]      nextByte;
  logic            toExpired;

  // Both transfer states share one datapath; only the selected scanner's
  // stream is looked at, the other one is ignored.
  always_comb begin
    xferB     = (state == XFER_B);
    curVld    = xferB ? vld_b : vld_a;
    curDat    = xferB ? dat_b : dat_a;
    nextByte  = {curDat, shiftReg[7:1]};
    toExpired = (toCnt == TO_ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd_a    <= CMD_NONE;
      cmd_b    <= CMD_NONE;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      toCnt    <= '0;
      bitCnt   <= '0;
      byteCnt  <= '0;
      shiftReg <= '0;
      rdyBSeen <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      // Latches any rdy_b; the START_B entry below clears it, so only
      // pulses from START_B onward survive into WAIT_B.
      if (rdy_b) rdyBSeen <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            err   <= 1'b0;
            busy  <= 1'b1;
            cmd_a <= CMD_SCAN;
            state <= START_A;
          end
        end

        START_A: begin
          cmd_a <= CMD_NONE;
          toCnt <= TO_LOAD;
          state <= WAIT_A;
        end

        WAIT_A: begin
          // rdy is checked before the terminal count so it wins a tie
          if (rdy_a) begin
            cmd_b    <= CMD_SCAN;
            rdyBSeen <= 1'b0;
            state    <= START_B;
          end else if (toExpired) begin
            cmd_a <= CMD_NONE;
            cmd_b <= CMD_NONE;
            err   <= 1'b1;
            state <= ERR;
          end else begin
            toCnt <= toCnt - TO_ONE;
          end
        end

        START_B: begin
          cmd_b    <= CMD_NONE;
          cmd_a    <= CMD_XFER;
          toCnt    <= TO_LOAD;
          bitCnt   <= '0;
          byteCnt  <= '0;
          shiftReg <= '0;
          state    <= XFER_A;
        end

        XFER_A, XFER_B: begin
          if (curVld) begin
            toCnt    <= TO_LOAD;
            shiftReg <= nextByte;
            bitCnt   <= bitCnt + 3'd1;
            if (xferB) cmd_b <= CMD_NONE;
            else       cmd_a <= CMD_NONE;
            if (bitCnt == 3'd7) begin
              wr_en   <= 1'b1;
              wr_addr <= {xferB, byteCnt};
              wr_data <= nextByte;
              byteCnt <= byteCnt + 4'd1;
              if (byteCnt == LAST_BYTE) begin
                state <= xferB ? FINISH : WAIT_B;
              end
            end
          end else if (toExpired) begin
            // partial byte in shiftReg is simply dropped
            cmd_a <= CMD_NONE;
            cmd_b <= CMD_NONE;
            err   <= 1'b1;
            state <= ERR;
          end else begin
            toCnt <= toCnt - TO_ONE;
          end
        end

        WAIT_B: begin
          if (rdyBSeen || rdy_b) begin
            cmd_b    <= CMD_XFER;
            toCnt    <= TO_LOAD;
            bitCnt   <= '0;
            byteCnt  <= '0;
            shiftReg <= '0;
            state    <= XFER_B;
          end else if (toExpired) begin
            cmd_a <= CMD_NONE;
            cmd_b <= CMD_NONE;
            err   <= 1'b1;
            state <= ERR;
          end else begin
            toCnt <= toCnt - TO_ONE;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer
//   Randomized bench for scan_sequencer. Scanner behaviour is driven from
//   byte arrays. The expected capture-buffer contents and latencies are
//   derived from those arrays and from the timeout value.
`timescale 1ns/1ps
module tb_scan_sequencer;

  localparam int NBYTES = 10;
  localparam int TMO    = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] cmd_a;
  logic       rdy_a;
  logic       vld_a;
  logic       dat_a;
  logic [1:0] cmd_b;
  logic       rdy_b;
  logic       vld_b;
  logic       dat_b;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;

  scan_sequencer #(
    .BYTES_PER_SCAN(NBYTES),
    .TIMEOUT(TMO),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cmd_a(cmd_a),
    .rdy_a(rdy_a),
    .vld_a(vld_a),
    .dat_a(dat_a),
    .cmd_b(cmd_b),
    .rdy_b(rdy_b),
    .vld_b(vld_b),
    .dat_b(dat_b),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // observed buffer writes {addr, data} and done pulses
  logic [12:0] wrLog[$];
  int          doneCnt = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wrLog.push_back({wr_addr, wr_data});
    if (done === 1'b1) doneCnt++;
  end

  logic [7:0] bytesA [NBYTES];
  logic [7:0] bytesB [NBYTES];

  task automatic beginRound();
    wrLog.delete();
    doneCnt = 0;
    for (int i = 0; i < NBYTES; i++) begin
      bytesA[i] = 8'($urandom_range(0, 255));
      bytesB[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic endRound();
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    vld_a = 1'b0;
    vld_b = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // expected writes: first nA bytes of A at 0.., then nB bytes of B at 16..
  task automatic checkWrites(input int nA, input int nB);
    logic [12:0] exp[$];
    for (int i = 0; i < nA; i++) exp.push_back({1'b0, 4'(i), bytesA[i]});
    for (int i = 0; i < nB; i++) exp.push_back({1'b1, 4'(i), bytesB[i]});
    checkVal("wrCount", wrLog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wrLog.size(); i++)
      checkVal($sformatf("wr%0d", i), 32'(wrLog[i]), 32'(exp[i]));
  endtask

  // one cycle of serial drive on scanner sel; the other scanner gets noise
  task automatic driveCycle(input bit sel, input bit v, input bit d, input bit pulseB);
    if (!sel) begin
      vld_a = v;
      dat_a = d;
      vld_b = 1'($urandom_range(0, 1));
      dat_b = 1'($urandom_range(0, 1));
    end else begin
      vld_b = v;
      dat_b = d;
      vld_a = 1'($urandom_range(0, 1));
      dat_a = 1'($urandom_range(0, 1));
    end
    rdy_b = pulseB;
    @(negedge clk);
  endtask

  task automatic sendBits(input bit sel, input int nBits, input int rdyBAt, input bit gaps);
    int idx = 0;
    logic [7:0] b;
    for (int k = 0; k < nBits; k++) begin
      int gap;
      gap = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g < gap; g++) begin
        driveCycle(sel, 1'b0, 1'b0, idx == rdyBAt);
        idx++;
      end
      b = sel ? bytesB[k / 8] : bytesA[k / 8];
      driveCycle(sel, 1'b1, b[k % 8], idx == rdyBAt);
      idx++;
    end
    vld_a = 1'b0;
    vld_b = 1'b0;
    dat_a = 1'b0;
    dat_b = 1'b0;
    rdy_b = 1'b0;
  endtask

  // start, scanner A progress after rdyDelay cycles, up to XFER_A
  task automatic kickOff(input int rdyDelay, input bit startNoise);
    int d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("cmdA_scan", cmd_a, 2'b01);
    checkVal("busy_on", busy, 1'b1);
    checkVal("err_cleared", err, 1'b0);
    d = (rdyDelay < 0) ? int'($urandom_range(1, 12)) : rdyDelay;
    repeat (d) begin
      start = startNoise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    rdy_a = 1'b1;
    @(negedge clk);
    checkVal("cmdB_scan", cmd_b, 2'b01);
    @(negedge clk);
    checkVal("cmdA_xfer", cmd_a, 2'b10);
    checkVal("cmdB_off", cmd_b, 2'b00);
  endtask

  task automatic roundNominal(input bit earlyB, input bit startNoise, input bit gaps, input int rdyDelay);
    beginRound();
    kickOff(rdyDelay, startNoise);
    sendBits(1'b0, 8 * NBYTES, earlyB ? int'($urandom_range(0, 60)) : -1, gaps);
    checkVal("cmdA_released", cmd_a, 2'b00);
    // a stray A bit past the final byte must be ignored
    vld_a = 1'($urandom_range(0, 1));
    dat_a = 1'($urandom_range(0, 1));
    if (earlyB) begin
      @(negedge clk);
      vld_a = 1'b0;
      checkVal("cmdB_xfer_early", cmd_b, 2'b10);
    end else begin
      int w;
      w = int'($urandom_range(0, 10));
      checkVal("cmdB_waiting", cmd_b, 2'b00);
      @(negedge clk);
      vld_a = 1'b0;
      repeat (w) @(negedge clk);
      checkVal("cmdB_still_waiting", cmd_b, 2'b00);
      rdy_b = 1'b1;
      @(negedge clk);
      rdy_b = 1'b0;
      checkVal("cmdB_xfer_late", cmd_b, 2'b10);
    end
    sendBits(1'b1, 8 * NBYTES, -1, gaps);
    @(negedge clk);
    checkVal("done_pulse", done, 1'b1);
    checkVal("busy_idle", busy, 1'b0);
    checkVal("err_ok", err, 1'b0);
    @(negedge clk);
    checkVal("done_once", done, 1'b0);
    checkWrites(NBYTES, NBYTES);
    checkVal("doneCount", doneCnt, 1);
    endRound();
  endtask

  task automatic roundRdyTimeout();
    int n;
    beginRound();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("cmdA_scan_to", cmd_a, 2'b01);
    n = 0;
    while (err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    // one START_A cycle plus TMO cycles in WAIT_A
    checkVal("rdyTimeoutLat", n, TMO + 1);
    checkVal("to_cmdA", cmd_a, 2'b00);
    checkVal("to_cmdB", cmd_b, 2'b00);
    checkVal("to_busy", busy, 1'b1);
    @(negedge clk);
    checkVal("to_busy_fall", busy, 1'b0);
    checkVal("to_err_held", err, 1'b1);
    checkWrites(0, 0);
    checkVal("to_doneCount", doneCnt, 0);
    endRound();
  endtask

  task automatic roundGap(input int nBits);
    int n;
    beginRound();
    kickOff(-1, 1'b0);
    sendBits(1'b0, nBits, -1, 1'b0);
    n = 1;
    while (err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkVal("gapTimeoutLat", n, TMO + 1);
    checkVal("gap_cmdA", cmd_a, 2'b00);
    checkVal("gap_wr_en", wr_en, 1'b0);
    @(negedge clk);
    checkVal("gap_busy_fall", busy, 1'b0);
    checkVal("gap_err_held", err, 1'b1);
    checkWrites(nBits / 8, 0);
    checkVal("gap_doneCount", doneCnt, 0);
    endRound();
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkVal({pfx, "_cmd_a"}, cmd_a, 2'b00);
    checkVal({pfx, "_cmd_b"}, cmd_b, 2'b00);
    checkVal({pfx, "_wr_en"}, wr_en, 1'b0);
    checkVal({pfx, "_wr_addr"}, wr_addr, 5'd0);
    checkVal({pfx, "_wr_data"}, wr_data, 8'd0);
    checkVal({pfx, "_busy"}, busy, 1'b0);
    checkVal({pfx, "_done"}, done, 1'b0);
    checkVal({pfx, "_err"}, err, 1'b0);
  endtask

  task automatic roundReset();
    logic [7:0] b;
    beginRound();
    kickOff(-1, 1'b1);
    sendBits(1'b0, 39, -1, 1'b0);
    // the 40th bit completes byte 4, but reset lands on the same edge
    b = bytesA[4];
    vld_a = 1'b1;
    dat_a = b[7];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vld_a = 1'b0;
    rdy_a = 1'b0;
    checkResetOutputs("midRst");
    @(negedge clk);
    checkVal("midRst_no_write", wr_en, 1'b0);
    checkWrites(4, 0);
    endRound();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    vld_a = 1'b0;
    vld_b = 1'b0;
    dat_a = 1'b0;
    dat_b = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);
    checkVal("idle_busy", busy, 1'b0);

    roundNominal(1'b0, 1'b1, 1'b0, 7);
    roundNominal(1'b1, 1'b0, 1'b0, 7);
    roundRdyTimeout();
    roundNominal(1'b0, 1'b0, 1'b1, -1);
    roundGap(19);
    roundNominal(1'b1, 1'b1, 1'b1, -1);
    roundReset();
    roundNominal(1'b0, 1'b0, 1'b0, -1);
    // rdy_a arrives on the very cycle the WAIT_A timer expires
    roundNominal(1'b1, 1'b1, 1'b0, TMO);

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 3) roundGap(int'($urandom_range(1, 79)));
      else roundNominal(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, got %0d failures so far, expected completion", testsFailed);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Processor-side controller for a pair of line scanners that share one capture path. It starts scanner A, then starts scanner B once A reports 80% progress, so the two scans overlap. It then commands each scanner's serial transfer in turn, deserializes the bits, and writes the bytes into a local 32x8 capture buffer. It also flags done on completion and error on timeout.

Parameters:
BYTES_PER_SCAN, 10, bytes expected from each scanner per transfer (1..16)
TIMEOUT, 255, max cycles to wait for a ready flag or for the next serial bit
TO_W, 8, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  one-cycle request to begin a scan round
cmd_a  out  2  command to scanner A: 00 none, 01 start scan, 10 transfer
rdy_a  in  1  scanner A 80%-progress flag
vld_a  in  1  scanner A serial bit valid (one bit per cycle while high)
dat_a  in  1  scanner A serial data
cmd_b  out  2  command to scanner B, same encoding
rdy_b  in  1  scanner B 80%-progress flag
vld_b  in  1  scanner B serial bit valid
dat_b  in  1  scanner B serial data
wr_en  out  1  capture buffer write strobe
wr_addr  out  5  [4]=scanner (0=A, 1=B), [3:0]=byte index
wr_data  out  8  assembled byte
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a round completes
err  out  1  sticky timeout flag, cleared by rst or by an accepted start

Behaviour:
- Reset is synchronous and active-high on rst, clocked on clk. On reset: state=IDLE, cmd_a=cmd_b=00, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0. All counters and the shift register are cleared.
- All outputs are registered.
- IDLE: start=1 clears err and moves to START_A.
- START_A: cmd_a=01 for exactly one cycle, then moves to WAIT_A. The timeout counter is cleared on entry.
- WAIT_A: waits for rdy_a=1, then moves to START_B. If TIMEOUT cycles elapse first, moves to ERR.
- START_B: cmd_b=01 for one cycle, then moves to XFER_A. A flag rdy_b_seen is cleared on entry and set on any cycle with rdy_b=1 from START_B onward.
- XFER_A:
  - cmd_a=10, held until the first vld_a=1, then 00.
  - On each vld_a=1, dat_a is shifted in LSB-first. Bit counter 0..7; byte counter 0..BYTES_PER_SCAN-1.
  - On the 8th bit of a byte, the next cycle gives wr_en=1, wr_addr={0,byte_idx}, wr_data=the byte.
  - After byte BYTES_PER_SCAN-1 is written, moves to WAIT_B.
  - The gap timeout (no vld_a for TIMEOUT cycles) applies from entry, and restarts on each bit.
- WAIT_B: moves to XFER_B when rdy_b_seen=1 (immediately if it is already set). Otherwise times out to ERR.
- XFER_B: same as XFER_A, using cmd_b, vld_b, dat_b, and wr_addr[4]=1. After the last write, moves to FINISH.
- FINISH: done=1 for one cycle, then moves to IDLE.
- ERR:
  - cmd_a=cmd_b=00, err=1, busy=1 for one cycle, then moves to IDLE with err held.
  - Any partial byte is discarded; no write occurs.
- Simultaneous events and boundaries:
  - start while busy=1 is ignored.
  - vld from the scanner not currently being transferred is ignored.
  - vld after the final byte of a transfer is ignored.
  - rdy_a during XFER states is ignored.
  - rdy and timeout expiring in the same cycle: rdy wins.
  - The byte counter does not wrap. The transfer ends at exactly BYTES_PER_SCAN bytes.
  - Reset mid-transfer aborts immediately: commands return to 00 and no pending write is issued.
- Latency:
  - First cmd_a=01 appears the cycle after start is sampled.
  - Each byte write appears 1 cycle after its 8th bit.
  - done appears 1 cycle after the last B write.

Test Plan:
- Nominal round:
  - Stimulus: start pulse; rdy_a after 7 cycles; rdy_b after 7 cycles; each scanner returns 80 contiguous bits encoding bytes 0..9 LSB-first.
  - Required: 10 writes at addr 0..9 with data 0..9, then 10 writes at addr 16..25 with data 0..9. Single done pulse; err=0; cmd_b=01 exactly one cycle after rdy_a.
- rdy_b early: rdy_b pulses during XFER_A.
  - Required: XFER_B starts with no wait in WAIT_B (cmd_b=10 the cycle after the last A write).
- Ready timeout: rdy_a never asserted.
  - Required: err=1 after 255 cycles in WAIT_A; no writes; cmds 00; busy falls.
  - Then a new start clears err and the round completes normally.
- Bit-gap timeout and interleaving:
  - Stimulus: vld_a stops after 19 bits.
  - Required: 2 writes (addr 0,1), then err; the partial 3rd byte is not written.
  - Stimulus: vld_b toggling during XFER_A.
  - Required: no effect on the captured data.
- Reset mid-transfer and start while busy:
  - Stimulus: rst asserted at bit 40 of XFER_A.
  - Required: next cycle all outputs at reset values; wr_en=0.
  - Stimulus: start pulses during WAIT_A.
  - Required: ignored, with only one done per round.
